ram_sp_param: RTL and testbench
===============================

// Module: ram_sp_param
// PURPOSE
//  Parametrised single-port synchronous RAM; successor to the fixed 8x4 memory.
//  Generic width/depth, registered read pipeline (1 or 2 cycles), rvalid strobe.
//  Self-initialising: a clear FSM sweeps every word to INIT_VAL after reset or on request.
//  Sits between a simple sel/wr master and local storage; master gates on ready.
// PARAMETERS
//  ADDR_W    3      address width in bits
//  DATA_W    4      word width in bits
//  DEPTH     8      number of words; 2 <= DEPTH <= 2**ADDR_W
//  RD_LAT    1      read latency in cycles; legal values 1 or 2 only
//  INIT_VAL  0      DATA_W-bit value written to every word during clear
// PORTS
//  clk     in   1       clock, all logic on rising edge
//  rst     in   1       asynchronous, active-high reset
//  sel     in   1       request strobe, sampled when ready=1
//  wr      in   1       1=write, 0=read; qualified by sel
//  addr    in   ADDR_W  word address
//  wdata   in   DATA_W  write data
//  clr     in   1       synchronous clear request, sampled in IDLE only
//  ready   out  1       1 in IDLE; 0 during CLEAR; requests ignored when 0
//  rdata   out  DATA_W  read data; holds last value between reads
//  rvalid  out  1       1-cycle pulse, coincident with new rdata
//  perr    out  1       parity error flag (PARITY_EN only; tied 0 otherwise)
// BEHAVIOUR
//  Reset (async): state=CLEAR, clr_cnt=0, ready=0, rdata=0, rvalid=0, perr=0, read pipe flushed.
//  FSM CLEAR: each cycle mem[clr_cnt]<=INIT_VAL, clr_cnt++; at clr_cnt==DEPTH-1 -> IDLE.
//   Clear takes exactly DEPTH cycles; ready rises the cycle after the last word is written.
//  FSM IDLE: clr=1 -> CLEAR (clr_cnt=0), takes priority over a same-cycle sel.
//  Write: sel&wr&ready at edge N -> mem[addr]<=wdata at edge N; no rvalid.
//  Read: sel&!wr&ready at edge N -> rdata/rvalid valid after edge N+RD_LAT-1+1
//   (RD_LAT=1: next cycle; RD_LAT=2: two cycles later). Back-to-back reads every cycle.
//  Read of a word written in an earlier cycle returns the new data (no stale read).
//  addr >= DEPTH: write dropped; read returns 0 with rvalid=1.
//  sel while ready=0: ignored, no rvalid, no memory change.
//  Reads in flight when clr accepted: pipeline drains, rvalid still issued with pre-clear data.
//  rst mid-CLEAR or mid-read: clear restarts from word 0, in-flight reads discarded.
//  DEPTH not a power of two: clr_cnt compares against DEPTH-1, never wraps past it.
// CONFIGURATION
//  Macro RAM_SP_PARITY_EN:
//   defined: each word stores DATA_W+1 bits (even parity over wdata); clear writes matching
//    parity for INIT_VAL; on read, perr pulses with rvalid if stored parity mismatches;
//    rdata still returned unmodified.
//   undefined: storage is DATA_W bits, perr tied to 0, no parity logic.
// STRUCTURE
//  Package ram_pkg: state typedef (CLEAR, IDLE), RD_LAT legal-value constants,
//   parity helper function.
//  Sub-module ram_sp_array: bare storage, one write port, one registered read port;
//   top holds FSM, clear counter, address-range check, read pipeline, parity check.
// TESTING
//  1 rst 1->0, DEPTH=8: ready=0 for 8 cycles then 1; read all addrs -> rdata=INIT_VAL.
//  2 write 0x3@0, 0xE@3, 0x9@2; read 0,3,2 back-to-back -> 0x3,0xE,0x9, rvalid each cycle.
//  3 RD_LAT=2: read 0x3@0 -> rvalid/rdata exactly 2 cycles after request.
//  4 DEPTH=6: write 0xF@7 then read 7 -> rdata=0, rvalid=1; words 0-5 unchanged.
//  5 clr with 1 read in flight: rvalid with old data, ready=0 for DEPTH cycles, reads -> INIT_VAL.
//  6 RAM_SP_PARITY_EN: force flip data bit of word 3, read 3 -> perr=1 with rvalid; others perr=0.

Source files
------------

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - state type, read-latency limits and parity helper shared by the RAM files
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ram_sp_array.sv
// rtl/ram_sp_array.sv - bare word storage with one write port and one registered read port
module ram_sp_array #(
  parameter int ADDR_W = 3,
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic              rd_zero,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_d, rd_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Out-of-range reads still complete, but return zero instead of touching storage.
  always_comb begin
    rd_d = rd_q;
    if (re) rd_d = rd_zero ? '0 : mem[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= '0;
    else     rd_q <= rd_d;
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/ram_sp_param.sv
// rtl/ram_sp_param.sv - self-clearing single-port RAM with 1/2-cycle read pipeline
// Optional parity storage and checking enabled by macro RAM_SP_PARITY_EN.
module ram_sp_param
  import ram_pkg::*;
#(
  parameter int              ADDR_W   = 3,
  parameter int              DATA_W   = 4,
  parameter int              DEPTH    = 8,
  parameter int              RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              perr
);

`ifdef RAM_SP_PARITY_EN
  localparam int SW = DATA_W + 1;
`else
  localparam int SW = DATA_W;
`endif
  localparam int RD_LAT_EFF = (RD_LAT >= RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT_MIN;

  state_e            state_d, state_q;
  logic [ADDR_W-1:0] clr_cnt_d, clr_cnt_q;
  logic              v1_q;
  logic              clearing, in_range, acc, last_word;
  logic              arr_we, arr_re;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] wsrc;
  logic [SW-1:0]     arr_wdata, rd_data;
  logic              perr_now;

  assign clearing  = (state_q == ST_CLEAR);
  assign ready     = (state_q == ST_IDLE);
  assign in_range  = (32'(addr) < DEPTH);
  assign last_word = (clr_cnt_q == ADDR_W'(DEPTH - 1));
  // A clear request wins over a request presented in the same cycle.
  assign acc       = ready & sel & ~clr;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (last_word) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end
      end
      default: begin
        if (clr) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      v1_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      v1_q      <= arr_re;
    end
  end

  assign arr_we    = clearing | (acc & wr & in_range);
  assign arr_waddr = clearing ? clr_cnt_q : addr;
  assign arr_re    = acc & ~wr;
  assign wsrc      = clearing ? INIT_VAL : wdata;

`ifdef RAM_SP_PARITY_EN
  assign arr_wdata = {even_parity(64'(wsrc)), wsrc};
  assign perr_now  = v1_q & (even_parity(64'(rd_data[DATA_W-1:0])) != rd_data[DATA_W]);
`else
  assign arr_wdata = wsrc;
  assign perr_now  = 1'b0;
`endif

  ram_sp_array #(
    .ADDR_W (ADDR_W),
    .WIDTH  (SW),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (arr_we),
    .waddr   (arr_waddr),
    .wdata   (arr_wdata),
    .re      (arr_re),
    .rd_zero (~in_range),
    .raddr   (addr),
    .rd_data (rd_data)
  );

  if (RD_LAT_EFF == RD_LAT_MIN) begin : g_lat1
    assign rdata  = rd_data[DATA_W-1:0];
    assign rvalid = v1_q;
    assign perr   = perr_now;
  end else begin : g_lat2
    logic [DATA_W-1:0] rdata_d, rdata_q;
    logic              rvalid_q, perr_q;

    always_comb begin
      rdata_d = rdata_q;
      if (v1_q) rdata_d = rd_data[DATA_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
        perr_q   <= 1'b0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= v1_q;
        perr_q   <= perr_now;
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign perr   = perr_q;
  end

endmodule

// File: tb/tb_ram_sp_param.sv
// tb/tb_ram_sp_param.sv - two RAM configurations (8x4 lat1, 6x4 lat2 init 5) against a cycle model
module tb_ram_sp_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0, wr = 1'b0, clr = 1'b0;
  logic [2:0] addr = '0;
  logic [3:0] wdata = '0;

  logic [1:0] ready_o, rvalid_o, perr_o;
  logic [3:0] rdata_o [2];

  always #5 clk = ~clk;

  ram_sp_param dut_a (
    .clk(clk), .rst(rst), .sel(sel), .wr(wr), .addr(addr), .wdata(wdata), .clr(clr),
    .ready(ready_o[0]), .rdata(rdata_o[0]), .rvalid(rvalid_o[0]), .perr(perr_o[0])
  );

  ram_sp_param #(.DEPTH(6), .RD_LAT(2), .INIT_VAL(4'h5)) dut_b (
    .clk(clk), .rst(rst), .sel(sel), .wr(wr), .addr(addr), .wdata(wdata), .clr(clr),
    .ready(ready_o[1]), .rdata(rdata_o[1]), .rvalid(rvalid_o[1]), .perr(perr_o[1])
  );

  int         depth_m [2] = '{8, 6};
  int         lat_m   [2] = '{1, 2};
  logic [3:0] init_m  [2] = '{4'h0, 4'h5};

  logic [3:0] mem_m [2][8];
  bit         bad_m [2][8];
  int         clr_left [2];
  bit         due_v [2];
  logic [3:0] due_d [2];
  bit         due_p [2];
  bit         exp_rvalid [2];
  logic [3:0] exp_rdata [2];
  bit         exp_perr [2];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Model of one clock edge, driven by the inputs the bench is presenting.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit nv, np;
      logic [3:0] nd;
      if (rst) begin
        clr_left[k]   = depth_m[k];
        due_v[k]      = 1'b0;
        exp_rvalid[k] = 1'b0;
        exp_rdata[k]  = 4'h0;
        exp_perr[k]   = 1'b0;
      end else begin
        nv = due_v[k]; nd = due_d[k]; np = due_p[k];
        due_v[k] = 1'b0;
        if (clr_left[k] > 0) begin
          mem_m[k][depth_m[k] - clr_left[k]] = init_m[k];
          bad_m[k][depth_m[k] - clr_left[k]] = 1'b0;
          clr_left[k]--;
        end else if (clr) begin
          clr_left[k] = depth_m[k];
        end else if (sel && wr) begin
          if (int'(addr) < depth_m[k]) begin
            mem_m[k][addr] = wdata;
            bad_m[k][addr] = 1'b0;
          end
        end else if (sel) begin
          logic [3:0] d;
          bit p;
          d = (int'(addr) < depth_m[k]) ? mem_m[k][addr] : 4'h0;
          p = (int'(addr) < depth_m[k]) ? bad_m[k][addr] : 1'b0;
          if (lat_m[k] == 1) begin
            nv = 1'b1; nd = d; np = p;
          end else begin
            due_v[k] = 1'b1; due_d[k] = d; due_p[k] = p;
          end
        end
        exp_rvalid[k] = nv;
        exp_perr[k]   = nv & np;
        if (nv) exp_rdata[k] = nd;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ready%0d t=%0t", k, $time), ready_o[k], (clr_left[k] == 0));
      chk($sformatf("rvalid%0d t=%0t", k, $time), rvalid_o[k], exp_rvalid[k]);
      chk($sformatf("rdata%0d t=%0t", k, $time), rdata_o[k], exp_rdata[k]);
      chk($sformatf("perr%0d t=%0t", k, $time), perr_o[k], exp_perr[k]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic req(input bit s, input bit w, input int a, input int d, input bit c);
    sel = s; wr = w; addr = 3'(a); wdata = 4'(d); clr = c;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) req(0, 0, 0, 0, 0);
  endtask

  task automatic read_all();
    for (int a = 0; a < 8; a++) req(1, 0, a, 0, 0);
    idle(3);
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 8; a++) begin
        mem_m[k][a] = init_m[k];
        bad_m[k][a] = 1'b0;
      end

    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(10);
    read_all();

    req(1, 1, 0, 4'h3, 0);
    req(1, 1, 3, 4'hE, 0);
    req(1, 1, 2, 4'h9, 0);
    req(1, 0, 0, 0, 0);
    req(1, 0, 3, 0, 0);
    req(1, 0, 2, 0, 0);
    idle(3);

    req(1, 1, 7, 4'hF, 0);
    req(1, 0, 7, 0, 0);
    req(1, 1, 6, 4'hA, 0);
    read_all();

    req(1, 0, 3, 0, 0);
    req(0, 0, 0, 0, 1);
    idle(10);
    read_all();

    req(1, 1, 1, 4'hC, 1);
    idle(10);
    req(1, 0, 1, 0, 0);
    idle(3);

`ifdef RAM_SP_PARITY_EN
    req(1, 1, 3, 4'h6, 0);
    idle(1);
    dut_a.u_array.mem[3][0] = ~dut_a.u_array.mem[3][0];
    mem_m[0][3] = mem_m[0][3] ^ 4'h1;
    bad_m[0][3] = 1'b1;
    req(1, 0, 3, 0, 0);
    req(1, 0, 2, 0, 0);
    req(1, 0, 3, 0, 0);
    idle(3);
`endif

    for (int i = 0; i < 400; i++) begin
      if (i == 150 || i == 303) begin
        rst = 1'b1;
        req(0, 0, 0, 0, 0);
        rst = 1'b0;
      end
      req(($urandom % 4) != 0, $urandom % 2, int'($urandom_range(0, 7)),
          int'($urandom_range(0, 15)), ($urandom % 40) == 0);
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
